gat_bram_loader: RTL and testbench

GAT_BRAM_LOADER -- requirements
Module: gat_bram_loader

---
 rtl/gat_bram_loader.sv | 195 +++++++++++++++++++
 tb/tb_gat_bram_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_bram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gat_bram_loader
// Description : Host-word to BRAM element loader with per-channel limits,
//               plus a one-outstanding feature BRAM read port.
// Revision    : 1.0 - initial release
// ============================================================================
module gat_bram_loader #(
    parameter int TOP_WIDTH   = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 20,
    parameter int FEAT_ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(NUM_CH)-1:0]  wr_ch,
    input  logic                       wr_pack,
    input  logic [ADDR_W+1:0]          wr_addr,
    input  logic [TOP_WIDTH-1:0]       wr_data,
    input  logic                       cfg_start,
    input  logic [NUM_CH*ADDR_W-1:0]   cfg_len,
    output logic [NUM_CH-1:0]          bram_we,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic [ELEM_WIDTH-1:0]      bram_din,
    output logic [NUM_CH-1:0]          load_done,
    output logic [NUM_CH-1:0]          err_ovf,
    output logic                       err_ch,
    output logic                       busy,
    input  logic                       rd_req,
    input  logic [FEAT_ADDR_W+1:0]     rd_addr,
    output logic                       rd_valid,
    output logic [TOP_WIDTH-1:0]       rd_data,
    output logic [FEAT_ADDR_W-1:0]     feat_bram_addrb,
    input  logic [TOP_WIDTH-1:0]       feat_bram_dout
);

    localparam int c_K     = TOP_WIDTH / ELEM_WIDTH;
    localparam int c_CH_W  = $clog2(NUM_CH);
    localparam int c_IDX_W = (c_K > 1) ? $clog2(c_K) : 1;
    localparam logic [ADDR_W-1:0]  c_K_A      = ADDR_W'(c_K);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_K - 1);
    localparam logic [c_CH_W:0]    c_NUM_CH   = (c_CH_W + 1)'(NUM_CH);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_EMIT = 1'b1;

    logic [0:0]            r_state;
    logic [c_CH_W-1:0]     r_ch;
    logic                  r_pack;
    logic [TOP_WIDTH-1:0]  r_data;
    logic [ADDR_W-1:0]     r_base;
    logic [c_IDX_W-1:0]    r_idx;
    logic [ADDR_W-1:0]     r_cnt [NUM_CH];
    logic [NUM_CH-1:0]     r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [ELEM_WIDTH-1:0] r_din;
    logic [NUM_CH-1:0]     r_done;
    logic [NUM_CH-1:0]     r_ovf;
    logic                  r_err_ch;
    logic                  r_rd_pend;
    logic                  r_rd_valid;
    logic [FEAT_ADDR_W-1:0] r_addrb;

    logic                  w_last;
    logic                  w_accept;
    logic                  w_advance;
    logic [c_CH_W-1:0]     w_src_ch;
    logic                  w_src_pack;
    logic [TOP_WIDTH-1:0]  w_src_data;
    logic [ADDR_W-1:0]     w_src_base;
    logic [c_IDX_W-1:0]    w_src_idx;
    logic [ADDR_W-1:0]     w_addr;
    logic [ELEM_WIDTH-1:0] w_din;
    logic [ADDR_W-1:0]     w_len [NUM_CH];
    logic                  w_rd_inflight;
    logic                  w_unused_ok;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_len
            assign w_len[g] = cfg_len[g*ADDR_W +: ADDR_W];
        end
    endgenerate

    // The element on the bram_* registers is r_idx of the captured word;
    // readiness on its last element lets the next word follow with no bubble.
    assign w_last    = !r_pack || (r_idx == c_LAST_IDX);
    assign wr_ready  = !rst && !cfg_start && ((r_state == c_IDLE) || w_last);
    assign w_accept  = wr_valid && wr_ready;
    assign w_advance = (r_state == c_EMIT) && !w_last;

    always_comb begin
        w_src_ch   = r_ch;
        w_src_pack = r_pack;
        w_src_data = r_data;
        w_src_base = r_base;
        w_src_idx  = r_idx + c_IDX_W'(1);
        if (w_accept) begin
            w_src_ch   = wr_ch;
            w_src_pack = wr_pack;
            w_src_data = wr_data;
            w_src_base = wr_addr[ADDR_W+1:2];
            w_src_idx  = '0;
        end
    end

    assign w_addr = w_src_pack ? (w_src_base * c_K_A + ADDR_W'(w_src_idx)) : w_src_base;
    assign w_din  = ELEM_WIDTH'(w_src_data >> (w_src_idx * ELEM_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_ch     <= '0;
            r_pack   <= 1'b0;
            r_data   <= '0;
            r_base   <= '0;
            r_idx    <= '0;
            r_we     <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_done   <= '0;
            r_ovf    <= '0;
            r_err_ch <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
        end else if (cfg_start) begin
            r_state  <= c_IDLE;
            r_we     <= '0;
            r_done   <= '0;
            r_ovf    <= '0;
            r_err_ch <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
        end else begin
            r_we <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if ((w_len[c] != '0) && (r_cnt[c] == w_len[c])) r_done[c] <= 1'b1;
            end
            if (w_accept && ({1'b0, wr_ch} >= c_NUM_CH)) r_err_ch <= 1'b1;
            if (w_accept || w_advance) begin
                r_state <= c_EMIT;
                r_ch    <= w_src_ch;
                r_pack  <= w_src_pack;
                r_data  <= w_src_data;
                r_base  <= w_src_base;
                r_idx   <= w_src_idx;
                r_addr  <= w_addr;
                r_din   <= w_din;
                // Invalid channels match no c, so their elements drain silently.
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_src_ch == c_CH_W'(c)) begin
                        if (r_cnt[c] != w_len[c]) begin
                            r_we[c]  <= 1'b1;
                            r_cnt[c] <= r_cnt[c] + ADDR_W'(1);
                        end else begin
                            r_ovf[c] <= 1'b1;
                        end
                    end
                end
            end else begin
                r_state <= c_IDLE;
            end
        end
    end

    assign w_rd_inflight = r_rd_pend || r_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_addrb    <= '0;
        end else begin
            r_rd_pend  <= rd_req && !w_rd_inflight;
            r_rd_valid <= r_rd_pend;
            if (rd_req && !w_rd_inflight) r_addrb <= rd_addr[FEAT_ADDR_W+1:2];
        end
    end

    // BRAM output register already holds the word during the rd_valid cycle.
    assign rd_data         = r_rd_valid ? feat_bram_dout : '0;
    assign rd_valid        = r_rd_valid;
    assign feat_bram_addrb = r_addrb;
    assign bram_we         = r_we;
    assign bram_addr       = r_addr;
    assign bram_din        = r_din;
    assign load_done       = r_done;
    assign err_ovf         = r_ovf;
    assign err_ch          = r_err_ch;
    assign busy            = (r_state == c_EMIT) || w_rd_inflight;
    assign w_unused_ok     = &{1'b0, wr_addr[1:0], rd_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_gat_bram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gat_bram_loader
// Description : Self-checking bench for gat_bram_loader with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gat_bram_loader;

    localparam int TOP_WIDTH   = 32;
    localparam int ELEM_WIDTH  = 8;
    localparam int NUM_CH      = 3;
    localparam int ADDR_W      = 20;
    localparam int FEAT_ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_ch = '0;
    logic        wr_pack = 1'b0;
    logic [21:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        cfg_start = 1'b0;
    logic [59:0] cfg_len = '0;
    logic [2:0]  bram_we;
    logic [19:0] bram_addr;
    logic [7:0]  bram_din;
    logic [2:0]  load_done;
    logic [2:0]  err_ovf;
    logic        err_ch;
    logic        busy;
    logic        rd_req = 1'b0;
    logic [17:0] rd_addr = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [15:0] feat_bram_addrb;
    logic [31:0] feat_bram_dout = '0;

    always #5 clk = ~clk;

    gat_bram_loader #(
        .TOP_WIDTH(TOP_WIDTH), .ELEM_WIDTH(ELEM_WIDTH), .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W), .FEAT_ADDR_W(FEAT_ADDR_W)
    ) u_dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_pack(wr_pack),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_start(cfg_start), .cfg_len(cfg_len),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .load_done(load_done), .err_ovf(err_ovf), .err_ch(err_ch), .busy(busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout)
    );

    function automatic logic [31:0] feat_val(input logic [15:0] a);
        if (a == 16'd4) return 32'hDEADBEEF;
        return {a, ~a} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) feat_bram_dout <= feat_val(feat_bram_addrb);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: ordered list of expected BRAM writes plus session state
    logic [30:0] exp_q[$];
    int          m_len [NUM_CH];
    int          m_cnt [NUM_CH];
    logic [2:0]  m_ovf;
    logic        m_err_ch;

    function automatic void model_clear();
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
        m_ovf    = '0;
        m_err_ch = 1'b0;
    endfunction

    function automatic logic [2:0] model_done();
        logic [2:0] d = '0;
        for (int c = 0; c < NUM_CH; c++) d[c] = (m_len[c] != 0) && (m_cnt[c] == m_len[c]);
        return d;
    endfunction

    function automatic void model_accept(input int ch, input bit pack, input logic [21:0] addr,
                                         input logic [31:0] data);
        int          n    = pack ? 4 : 1;
        int          base = int'(addr[21:2]);
        int          a;
        logic [2:0]  oh;
        if (ch >= NUM_CH) begin
            m_err_ch = 1'b1;
            return;
        end
        oh = 3'b001 << ch;
        for (int i = 0; i < n; i++) begin
            if (m_cnt[ch] == m_len[ch]) begin
                m_ovf[ch] = 1'b1;
            end else begin
                a = pack ? ((base * 4 + i) & 32'hFFFFF) : base;
                exp_q.push_back({oh, a[19:0], data[8*i +: 8]});
                m_cnt[ch]++;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (bram_we != 3'b000) begin
            if (exp_q.size() == 0)
                check("bram_wr_unexpected", 64'({bram_we, bram_addr, bram_din}), 64'd0);
            else
                check("bram_wr", 64'({bram_we, bram_addr, bram_din}), 64'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic session(input int l0, input int l1, input int l2);
        step();
        cfg_len   = {20'(l2), 20'(l1), 20'(l0)};
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        m_len[0] = l0; m_len[1] = l1; m_len[2] = l2;
        model_clear();
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic wr(input int ch, input bit pack, input logic [21:0] addr,
                      input logic [31:0] data, output int waits);
        wr_valid = 1'b1; wr_ch = 2'(ch); wr_pack = pack; wr_addr = addr; wr_data = data;
        waits = 0;
        @(negedge clk);
        while (!wr_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!wr_ready) begin
            check("wr_ready_timeout", 64'(wr_ready), 64'd1);
            wr_valid = 1'b0;
            return;
        end
        model_accept(ch, pack, addr, data);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(bram_we == 3'b000 && wr_ready && exp_q.size() == 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_flags();
        check("load_done", 64'(load_done), 64'(model_done()));
        check("err_ovf", 64'(err_ovf), 64'(m_ovf));
        check("err_ch", 64'(err_ch), 64'(m_err_ch));
    endtask

    task automatic do_read(input logic [17:0] addr);
        step();
        rd_req = 1'b1; rd_addr = addr;
        step();
        rd_req = 1'b0;
        @(negedge clk);
        check("rd_addrb", 64'(feat_bram_addrb), 64'(addr[17:2]));
        check("rd_valid_early", 64'(rd_valid), 64'd0);
        @(negedge clk);
        check("rd_valid", 64'(rd_valid), 64'd1);
        check("rd_data", 64'(rd_data), 64'(feat_val(addr[17:2])));
        @(negedge clk);
        check("rd_valid_pulse", 64'(rd_valid), 64'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [31:0] d;
        for (int c = 0; c < NUM_CH; c++) m_len[c] = 0;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_din", 64'(bram_din), 64'd0);
        check("rst_flags", 64'({load_done, err_ovf, err_ch}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd", 64'({rd_valid, rd_data}), 64'd0);
        check("rst_addrb", 64'(feat_bram_addrb), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(wr_ready), 64'd1);

        // Packed word, four elements then load_done
        session(4, 0, 0);
        d = 32'h44332211;
        wr(0, 1'b1, 22'h8, d, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pk_we", 64'(bram_we), 64'd1);
            check("pk_addr", 64'(bram_addr), 64'(8 + i));
            check("pk_din", 64'(bram_din), 64'(d[8*i +: 8]));
            if (i == 3) check("pk_done_early", 64'(load_done), 64'd0);
        end
        @(negedge clk);
        check("pk_done", 64'(load_done), 64'd1);
        check("pk_we_off", 64'(bram_we), 64'd0);

        // Back-to-back unpacked words on channel 2
        session(0, 0, 2);
        wr(2, 1'b0, 22'h0, 32'h0000005A, w);
        wr(2, 1'b0, 22'h4, 32'h000000A5, w);
        check("b2b_no_bubble", 64'(w), 64'd0);
        @(negedge clk);
        check("b2b_second", 64'({bram_we, bram_addr, bram_din}), 64'({3'b100, 20'd1, 8'hA5}));
        wait_idle();
        check_flags();

        // Overflow on channel 1
        session(0, 1, 0);
        wr(1, 1'b1, 22'h40, 32'hCAFEF00D, w);
        wait_idle();
        check("ovf_flag", 64'(err_ovf), 64'd2);
        check("ovf_done", 64'(load_done), 64'd2);

        // Invalid channel
        session(1, 1, 1);
        wr(3, 1'b1, 22'h0, 32'h12345678, w);
        wait_idle();
        check("badch_set", 64'(err_ch), 64'd1);
        check_flags();
        session(1, 1, 1);
        @(negedge clk);
        check("badch_clr", 64'(err_ch), 64'd0);

        // cfg_start on the second emit cycle aborts the word
        session(4, 0, 0);
        wr(0, 1'b1, 22'h0, 32'hDDCCBBAA, w);
        step();
        cfg_start = 1'b1;
        @(negedge clk);
        check("abort_ready_low", 64'(wr_ready), 64'd0);
        check("abort_elem1", 64'(bram_we), 64'd1);
        step();
        cfg_start = 1'b0;
        model_clear();
        @(negedge clk);
        check("abort_ready_high", 64'(wr_ready), 64'd1);
        check("abort_we_off", 64'(bram_we), 64'd0);
        step();
        wr(0, 1'b1, 22'h10, 32'h87654321, w);
        wait_idle();
        check("abort_cnt_clr_done", 64'(load_done), 64'd1);
        check("abort_cnt_clr_ovf", 64'(err_ovf), 64'd0);

        // Read path and ignored second request
        step();
        rd_req = 1'b1; rd_addr = 18'h10;
        step();
        rd_addr = 18'h20;
        @(negedge clk);
        check("rd0_addrb", 64'(feat_bram_addrb), 64'd4);
        step();
        rd_req = 1'b0;
        @(negedge clk);
        check("rd0_valid", 64'(rd_valid), 64'd1);
        check("rd0_data", 64'(rd_data), 64'hDEADBEEF);
        check("rd0_addrb_hold", 64'(feat_bram_addrb), 64'd4);
        @(negedge clk);
        check("rd0_pulse", 64'(rd_valid), 64'd0);
        @(negedge clk);
        check("rd0_second_ignored", 64'(rd_valid), 64'd0);

        // Reset mid-emit and mid-read
        session(8, 8, 8);
        wr(1, 1'b1, 22'h0, 32'h0F0E0D0C, w);
        rd_req = 1'b1; rd_addr = 18'h30;
        step();
        rd_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_we", 64'(bram_we), 64'd0);
            check("rstmid_rd", 64'(rd_valid), 64'd0);
        end

        // Randomized sessions with concurrent reads
        fork
            begin
                for (int s = 0; s < 6; s++) begin
                    session($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6));
                    for (int k = 0; k < 14; k++) begin
                        int g;
                        wr(($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                           1'($urandom_range(0, 1)), 22'($urandom()), $urandom(), w);
                        g = $urandom_range(0, 2);
                        if (g > 0) begin
                            repeat (g) @(posedge clk);
                            #1;
                        end
                    end
                    wait_idle();
                    check_flags();
                end
            end
            begin
                for (int r = 0; r < 25; r++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_read(18'($urandom()));
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
